mem_dados_sinc: RTL and testbench
=================================

// Module: mem_dados_sinc
// PURPOSE
//  Parametrised synchronous data memory with a valid/ready request port and fixed-latency response port.
//  Successor to the combinational memoriaBloco: adds clocking, byte enables, configurable width/depth,
//  pipelined read latency, self zero-fill after reset and error reporting.
//  Sits between the datapath load/store stage and the data address space.
// PARAMETERS
//  DATA_W    32   word width in bits; must be a multiple of 8
//  DEPTH     256  number of words
//  ADDR_W    32   byte-address width of req_addr
//  READ_LAT  1    response latency in cycles after acceptance; legal range 1..4
// PORTS
//  clock        in   1          rising-edge clock; the only clock
//  reset_n      in   1          synchronous active-low reset
//  req_valid    in   1          request present
//  req_ready    out  1          memory can accept a request this cycle
//  req_write    in   1          1 = write, 0 = read
//  req_addr     in   ADDR_W     byte address
//  req_wdata    in   DATA_W     write data
//  req_be       in   DATA_W/8   byte enables for writes; ignored on reads
//  resp_valid   out  1          one-cycle pulse per accepted request
//  resp_rdata   out  DATA_W     read data; 0 for writes and errored requests
//  resp_error   out  1          qualified by resp_valid: misaligned, out-of-range or parity fault
//  init_done    out  1          zero-fill finished
// BEHAVIOUR
//  - Reset (reset_n=0 at a clock edge): req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, init_done=0.
//    In-flight responses are discarded. The FSM enters INIT; a reset mid-operation behaves the same way.
//  - FSM states:
//    INIT: a word counter writes 0 to words 0..DEPTH-1, one word per cycle. req_ready=0.
//          After word DEPTH-1 -> RUN, and init_done=1 from the next cycle.
//    RUN:  req_ready=1 continuously. No backpressure on the response side.
//  - Accept = req_valid & req_ready. Every accepted request yields exactly one resp_valid pulse,
//    exactly READ_LAT cycles later. Responses are in order; one request per cycle is sustained.
//  - Word index = req_addr[ADDR_W-1:log2(DATA_W/8)].
//    Misaligned (low byte bits != 0) -> error; index >= DEPTH -> error.
//    Errored writes leave memory unchanged.
//  - Writes: the enabled bytes are updated at the accept edge. Response: rdata=0, error=0 unless faulted.
//  - Reads: sample the array at the accept edge, then pass through READ_LAT-1 pipeline stages.
//    A read accepted the cycle after a write to the same word returns the new data.
//  - req_valid while req_ready=0 is ignored; the requester holds it. Lines with resp_valid=0 are 0.
// CONFIGURATION
//  MEM_PARITY_EN defined:
//    - one even-parity bit is stored per byte, written with its byte; INIT writes parity 0.
//    - a read with any byte parity mismatch -> resp_error=1, resp_rdata=stored data.
//  MEM_PARITY_EN undefined:
//    - no parity storage; resp_error comes only from misaligned or out-of-range requests.
// STRUCTURE
//  - Package mem_pkg: the INIT/RUN state typedef, the READ_LAT range bounds, and a function
//    computing the byte-offset bit count from DATA_W.
//  - Sub-module mem_resp_pipe: a READ_LAT-deep valid/data/error shift register, cleared by reset_n.
//  - The top level holds the FSM, the init counter, the address checks and the array.
// TESTING
//  1. Release reset -> req_ready=0 for DEPTH cycles, then 1 and init_done=1;
//     read addr 0x10 -> resp_rdata=0, resp_error=0.
//  2. Write addr 0x4 data 100 be 4'hF, next cycle read addr 0x4 -> resp_valid READ_LAT cycles later, rdata=100.
//  3. Write 0x4 = 0xAABBCCDD be 4'hF, then write 0x4 = 0x11223344 be 4'b0010
//     -> read 0x4 returns 0xAABB33DD.
//  4. Write addr 0x6 -> resp_error=1 and word 1 unchanged; read addr 4*DEPTH -> resp_error=1, rdata=0.
//  5. READ_LAT=3: reads to 0x0,0x4,0x8 on consecutive cycles -> three consecutive responses in order.
//  6. Assert reset_n=0 with two reads in flight -> resp_valid=0 from the next edge with no stale
//     responses, and INIT re-zeroes memory. With MEM_PARITY_EN, flip a stored bit via hierarchical
//     force -> that read returns resp_error=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the synchronous data memory (mem_dados_sinc).
package mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_state_e;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;

    function automatic int byte_off_bits(input int data_w);
        return (data_w <= 8) ? 0 : $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-depth response shift register carrying valid, read data and error flag.
module mem_resp_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              error_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              error_o
);

    logic              vld_q  [STAGES];
    logic [DATA_W-1:0] data_q [STAGES];
    logic              err_q  [STAGES];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s]  <= 1'b0;
                data_q[s] <= '0;
                err_q[s]  <= 1'b0;
            end
        end else begin
            vld_q[0]  <= valid_i;
            data_q[0] <= data_i;
            err_q[0]  <= error_i;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s]  <= vld_q[s-1];
                data_q[s] <= data_q[s-1];
                err_q[s]  <= err_q[s-1];
            end
        end
    end

    assign valid_o = vld_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];
    assign error_o = err_q[STAGES-1];

endmodule

// File: rtl/mem_dados_sinc.sv
// Synchronous data memory: valid/ready request port, fixed-latency responses, zero-fill after reset.
// Optional byte parity storage and checking enabled by defining MEM_PARITY_EN.
module mem_dados_sinc
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_error,
    output logic                init_done
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = byte_off_bits(DATA_W);
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_lat_check
        $error("mem_dados_sinc: READ_LAT out of range");
    end

    mem_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_ready_q;
    logic              init_done_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [CNT_W-1:0]  idx_w;
    logic              misaligned;
    logic              in_range;
    logic              addr_err;
    logic              accept;
    logic              wr_en;
    logic              init_we;
    logic              par_fault;
    logic [DATA_W-1:0] rd_word;
    logic              rsp_vld_d;
    logic [DATA_W-1:0] rsp_data_d;
    logic              rsp_err_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == CNT_W'(DEPTH - 1)) begin
                        state_q     <= ST_RUN;
                        req_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    init_done_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign init_done  = init_done_q;

    assign word_idx   = req_addr >> OFF_W;
    assign idx_w      = word_idx[CNT_W-1:0];
    assign misaligned = |(req_addr & ADDR_W'(BYTES - 1));
    assign in_range   = (word_idx < ADDR_W'(DEPTH));
    assign addr_err   = misaligned | ~in_range;
    assign accept     = req_valid & req_ready_q;
    assign wr_en      = accept & req_write & ~addr_err;
    // The zero-fill owns the write port while INIT runs; requests are blocked then.
    assign init_we    = (state_q == ST_INIT) & reset_n;

    always_ff @(posedge clock) begin
        if (init_we) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_be[b]) begin
                    mem_q[idx_w][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem_q[idx_w];
        end
    end

`ifdef MEM_PARITY_EN
    logic [BYTES-1:0] par_q [DEPTH];

    always_ff @(posedge clock) begin
        if (init_we) begin
            par_q[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_be[b]) begin
                    par_q[idx_w][b] <= ^req_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        par_fault = 1'b0;
        if (in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (par_q[idx_w][b] != ^rd_word[b*8 +: 8]) begin
                    par_fault = 1'b1;
                end
            end
        end
    end
`else
    assign par_fault = 1'b0;
`endif

    // Writes and address faults answer with zero data; parity faults still return the stored word.
    assign rsp_vld_d  = accept;
    assign rsp_data_d = (accept & ~req_write & ~addr_err) ? rd_word : '0;
    assign rsp_err_d  = accept & (addr_err | (~req_write & par_fault));

    mem_resp_pipe #(
        .DATA_W (DATA_W),
        .STAGES (READ_LAT)
    ) u_resp_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .valid_i (rsp_vld_d),
        .data_i  (rsp_data_d),
        .error_i (rsp_err_d),
        .valid_o (resp_valid),
        .data_o  (resp_rdata),
        .error_o (resp_error)
    );

endmodule

// File: tb/tb_mem_dados_sinc.sv
// Directed self-checking bench for mem_dados_sinc (DEPTH=16, READ_LAT=3).
module tb_mem_dados_sinc;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 32;
    localparam int READ_LAT = 3;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;
    logic              init_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic [31:0] cyc;
    } resp_t;

    resp_t rq[$];
    int    acc_q[$];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (resp_valid === 1'b1) rq.push_back({resp_rdata, resp_error, 32'(cyc)});
    end

    mem_dados_sinc #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .init_done  (init_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        @(posedge clock);
        #1;
        acc_q.push_back(cyc);
    endtask

    task automatic get_resp(input string tag, input logic [31:0] exp_rd, input logic exp_err);
        int    n = 0;
        int    a;
        resp_t r;
        while (rq.size() == 0 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_present"}, 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0 && acc_q.size() != 0) begin
            r = rq.pop_front();
            a = acc_q.pop_front();
            check({tag, "_rdata"}, r.rd, exp_rd);
            check({tag, "_error"}, 32'(r.err), 32'(exp_err));
            check({tag, "_latency"}, r.cyc - 32'(a), 32'(READ_LAT - 1));
        end
    endtask

    task automatic wait_ready(input string tag);
        int zeros = 0;
        @(negedge clock);
        while (req_ready !== 1'b1 && zeros < 200) begin
            zeros++;
            @(negedge clock);
        end
        check({tag, "_init_cycles"}, 32'(zeros), 32'(DEPTH));
        check({tag, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);

        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_ready("boot");

        send(1'b0, 32'h10, 32'h0, 4'h0);
        idle();
        get_resp("rd_0x10", 32'h0, 1'b0);

        send(1'b1, 32'h4, 32'd100, 4'hF);
        send(1'b0, 32'h4, 32'h0, 4'h0);
        idle();
        get_resp("wr_0x4", 32'h0, 1'b0);
        get_resp("rd_after_wr", 32'd100, 1'b0);

        send(1'b1, 32'h4, 32'hAABBCCDD, 4'hF);
        send(1'b1, 32'h4, 32'h11223344, 4'b0010);
        send(1'b0, 32'h4, 32'h0, 4'h0);
        idle();
        get_resp("wr_full", 32'h0, 1'b0);
        get_resp("wr_byte1", 32'h0, 1'b0);
        get_resp("rd_merged", 32'hAABB33DD, 1'b0);

        send(1'b1, 32'h6, 32'hFFFFFFFF, 4'hF);
        send(1'b0, 32'h4, 32'h0, 4'h0);
        send(1'b0, 32'h40, 32'h0, 4'h0);
        send(1'b0, 32'h5, 32'h0, 4'h0);
        send(1'b1, 32'h40, 32'h12345678, 4'hF);
        send(1'b0, 32'h3C, 32'h0, 4'h0);
        idle();
        get_resp("wr_misaligned", 32'h0, 1'b1);
        get_resp("rd_word1_kept", 32'hAABB33DD, 1'b0);
        get_resp("rd_out_of_range", 32'h0, 1'b1);
        get_resp("rd_misaligned", 32'h0, 1'b1);
        get_resp("wr_out_of_range", 32'h0, 1'b1);
        get_resp("rd_last_word", 32'h0, 1'b0);

        send(1'b1, 32'h0, 32'h00000001, 4'hF);
        send(1'b1, 32'h8, 32'h00000003, 4'hF);
        send(1'b0, 32'h0, 32'h0, 4'h0);
        send(1'b0, 32'h4, 32'h0, 4'h0);
        send(1'b0, 32'h8, 32'h0, 4'h0);
        idle();
        get_resp("wr_w0", 32'h0, 1'b0);
        get_resp("wr_w2", 32'h0, 1'b0);
        get_resp("burst_rd0", 32'h00000001, 1'b0);
        get_resp("burst_rd1", 32'hAABB33DD, 1'b0);
        get_resp("burst_rd2", 32'h00000003, 1'b0);

        rq.delete();
        acc_q.delete();
        send(1'b0, 32'h0, 32'h0, 4'h0);
        send(1'b0, 32'h4, 32'h0, 4'h0);
        idle();
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_resp_rdata", resp_rdata, 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        acc_q.delete();
        wait_ready("reinit");
        check("midrst_no_stale", 32'(rq.size()), 32'd0);

        send(1'b0, 32'h0, 32'h0, 4'h0);
        send(1'b0, 32'h4, 32'h0, 4'h0);
        send(1'b0, 32'h8, 32'h0, 4'h0);
        idle();
        get_resp("rezero_w0", 32'h0, 1'b0);
        get_resp("rezero_w1", 32'h0, 1'b0);
        get_resp("rezero_w2", 32'h0, 1'b0);

`ifdef MEM_PARITY_EN
        send(1'b1, 32'h8, 32'h0000000F, 4'hF);
        send(1'b0, 32'h8, 32'h0, 4'h0);
        idle();
        get_resp("par_wr", 32'h0, 1'b0);
        get_resp("par_clean_rd", 32'h0000000F, 1'b0);
        force dut.mem_q[2] = 32'h0000000E;
        send(1'b0, 32'h8, 32'h0, 4'h0);
        idle();
        get_resp("par_fault_rd", 32'h0000000E, 1'b1);
        release dut.mem_q[2];
`endif

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
